odo_round_scheduler: RTL and testbench
======================================

# odo_round_scheduler

Sequencer for the Odo round pipeline. On `start`, it:
- latches the epoch `period`;
- drives it to the external round-key ROM (`odo_get_round_key*` family: registered, one-cycle, 10-bit key per period 0..9);
- captures the returned key once the ROM latency has elapsed;
- issues `ROUNDS` round tokens to the round datapath over a valid/ready handshake, then pulses `done`.

It sits between the nonce/job front end and the Odo permutation datapath.

## Interface
Parameters:
- `ROUNDS`, 84: rounds issued per job; must be ≥ 1.
- `KEY_W`, 10: round-key width; matches the ROM output.
- `ROM_LAT`, 1: ROM read latency in cycles; must be ≥ 1.
- `IDX_W`, 7: round index width; must be ≥ clog2(`ROUNDS`).

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  job request; sampled only in IDLE.
- `period_in`  in  4  epoch period for the job.
- `busy`  out  1  high in every state except IDLE.
- `rom_period`  out  4  address to the key ROM; registered.
- `rom_key`  in  KEY_W  ROM data output.
- `round_valid`  out  1  round token valid.
- `round_ready`  in  1  datapath accepts token.
- `round_idx`  out  IDX_W  current round number, 0..`ROUNDS`-1.
- `round_key`  out  KEY_W  captured key; constant for the whole job.
- `last_round`  out  1  high with `round_valid` when `round_idx` == `ROUNDS`-1.
- `done`  out  1  one-cycle pulse after the final transfer.
- `err`  out  1  one-cycle pulse on a rejected start; present only with the macro.

## Operation
FSM states and transitions:
- **IDLE**
  - `start`=1 → latch `rom_period`←`period_in`, clear `round_idx`, load wait counter ← `ROM_LAT`, go to FETCH.
- **FETCH**
  - Decrement the wait counter each cycle.
  - When it is 0: `round_key`←`rom_key`, go to ISSUE.
  - FETCH occupies `ROM_LAT`+1 cycles.
- **ISSUE**
  - `round_valid`=1.
  - `round_idx` and `round_key` must hold stable while `round_ready`=0.
  - Transfer occurs when `round_valid` & `round_ready`:
    - if not last: `round_idx`+1;
    - if last: go to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.

Other rules:
- `rom_period` is held stable from job start until the next accepted start, including in IDLE, so the ROM keeps re-presenting the same key.
- `start` in any state other than IDLE is ignored: no queueing, no error.
- `round_idx` never wraps. The transition to DONE replaces increment-to-`ROUNDS`, and the index returns to 0 only at the next accepted start.
- `ROUNDS`=1: the first token has `last_round`=1.
- Reset value of every output is 0. State resets to IDLE; wait counter resets to 0.
- Reset mid-operation (any state) has priority over all transitions. Outputs are 0 on the next edge, with no `done` and no `err`. The datapath discards any partial job.

## Timing
- `start` sampled high at edge E0:
  - FETCH occupies the cycles after E0 through E0+`ROM_LAT`+1.
  - `round_valid` first high in cycle E0+`ROM_LAT`+2 (cycle 3 after start for `ROM_LAT`=1).
- With `round_ready` tied high:
  - one transfer per cycle, `ROUNDS` consecutive cycles;
  - `done` in the cycle after the last transfer;
  - IDLE in the following cycle;
  - the next `start` is accepted on that IDLE cycle.
- Job length with `ready`=1: `ROM_LAT`+1+`ROUNDS`+1 cycles from start acceptance to return to IDLE.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- No combinational path from any input to any output.

## Configuration
Macro `ODO_SCHED_PERIOD_CHECK_EN`.
- **Defined:**
  - `start` with `period_in` > 9 is rejected.
  - The FSM stays in IDLE, `busy` stays 0 and `rom_period` is unchanged.
  - `err` pulses high for exactly the cycle after the start.
- **Undefined:**
  - The `err` port and its logic are absent, and every period is accepted.
  - For period > 9 the ROM returns whatever key it last held, and the job runs normally with that key.

## Structure
- Package `odo_pkg` holds:
  - `ODO_NUM_PERIODS` = 10;
  - `ODO_ROUNDS` = 84;
  - `ODO_KEY_W` = 10;
  - the FSM state typedef: IDLE, FETCH, ISSUE, DONE.
- One sub-module, `odo_round_ctr`: the round index register with clear, increment-on-transfer and `last_round` compare.
- The key ROM is external and is not instantiated here.

## Test plan
- **Basic job, no backpressure.** Reset, then `period_in`=0, `start` 1 cycle, `round_ready`=1, `ROM_LAT`=1 with the period-0 key ROM.
  - `round_valid` first high on cycle 3 with `round_key`=0x0b5.
  - 84 consecutive tokens, idx 0..83, with `last_round` only at 83.
  - `done` on the cycle after, `busy` low one cycle later.
- **Backpressure.** `period_in`=2, `round_ready` toggled 1,0,0,1,...
  - Transfers occur only on ready=1.
  - idx/key (0x26c) stay stable during stalls.
  - Exactly 84 transfers, then one `done`.
- **Start while busy.** `start` pulsed mid-job with `period_in`=4.
  - Ignored: `rom_period` stays 2.
  - Job completes normally, with no second job afterward.
- **Reset mid-ISSUE.** `rst_n`=0 at idx 40.
  - All outputs 0 on the next edge, with no `done`.
  - A new start after reset runs from idx 0.
- **Invalid period, macro defined.** `period_in`=11 with `start`.
  - `err`=1 for one cycle, `busy` stays 0, `rom_period` unchanged.
  - Macro undefined: the job runs with `busy` high.
- **Back-to-back jobs and `ROUNDS`=1 variant.** `start` held high continuously.
  - The second job is accepted on the IDLE cycle after `done`.
  - With `ROUNDS`=1, a single token with `last_round`=1, then `done`.

Source files
------------

// File: rtl/odo_pkg.sv
// Shared constants and FSM encoding for the Odo round scheduler.
// Imported by the scheduler top and its round counter.
package odo_pkg;

    // Key ROM holds one key per epoch period 0..ODO_NUM_PERIODS-1
    localparam int ODO_NUM_PERIODS = 10;
    localparam int ODO_ROUNDS      = 84;
    localparam int ODO_KEY_W       = 10;
    localparam int ODO_PERIOD_W    = 4;

    // Scheduler FSM encoding
    typedef logic [1:0] odo_state_t;

    localparam odo_state_t S_IDLE  = 2'd0;
    localparam odo_state_t S_FETCH = 2'd1;
    localparam odo_state_t S_ISSUE = 2'd2;
    localparam odo_state_t S_DONE  = 2'd3;

    // True when the ROM holds a key for this period
    function automatic logic odo_period_ok(
        input logic [ODO_PERIOD_W-1:0] p
    );
        return p < ODO_PERIOD_W'(ODO_NUM_PERIODS);
    endfunction

endpackage

// File: rtl/odo_round_ctr.sv
// Round index register for the Odo scheduler.
// Clears on job start, steps on each non-final transfer, flags the last round.
module odo_round_ctr
    import odo_pkg::*;
#(
    parameter int ROUNDS = ODO_ROUNDS,
    parameter int IDX_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             at_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    // Index register: clear has priority over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + IDX_W'(1);
        end
    end

    assign at_last = (idx == LAST_IDX);

endmodule

// File: rtl/odo_round_scheduler.sv
// Odo round scheduler: fetches the epoch key, then issues ROUNDS tokens.
// Macro ODO_SCHED_PERIOD_CHECK_EN adds the err port and period check.
module odo_round_scheduler
    import odo_pkg::*;
#(
    parameter int ROUNDS  = ODO_ROUNDS,
    parameter int KEY_W   = ODO_KEY_W,
    parameter int ROM_LAT = 1,
    parameter int IDX_W   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       period_in,
    output logic             busy,
    output logic [3:0]       rom_period,
    input  logic [KEY_W-1:0] rom_key,
    output logic             round_valid,
    input  logic             round_ready,
    output logic [IDX_W-1:0] round_idx,
    output logic [KEY_W-1:0] round_key,
    output logic             last_round,
    output logic             done
`ifdef ODO_SCHED_PERIOD_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int WC_W = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);

    odo_state_t      state;
    odo_state_t      state_nx;
    logic [WC_W-1:0] wcnt;
    logic            idle;
    logic            accept;
    logic            fetch_end;
    logic            xfer;
    logic            at_last;
    logic            ctr_inc;

    assign idle = (state == S_IDLE);

`ifdef ODO_SCHED_PERIOD_CHECK_EN
    assign accept = idle & start & odo_period_ok(period_in);
`else
    assign accept = idle & start;
`endif

    assign fetch_end = (state == S_FETCH) && (wcnt == '0);
    assign xfer      = round_valid & round_ready;
    assign ctr_inc   = xfer & ~at_last;

    // Next-state selection
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept) state_nx = S_FETCH;
            S_FETCH: if (fetch_end) state_nx = S_ISSUE;
            S_ISSUE: if (xfer && at_last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ROM latency counter: loaded on start, counts down through FETCH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (accept) begin
            wcnt <= WC_W'(ROM_LAT);
        end else if (state == S_FETCH && wcnt != '0) begin
            wcnt <= wcnt - WC_W'(1);
        end
    end

    // ROM address held from start to the next accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_period <= '0;
        end else if (accept) begin
            rom_period <= period_in;
        end
    end

    // Key captured once the ROM latency has elapsed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            round_key <= '0;
        end else if (fetch_end) begin
            round_key <= rom_key;
        end
    end

`ifdef ODO_SCHED_PERIOD_CHECK_EN
    // One-cycle pulse for a start carrying a period without a key
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= idle & start & ~odo_period_ok(period_in);
        end
    end
`endif

    odo_round_ctr #(
        .ROUNDS (ROUNDS),
        .IDX_W  (IDX_W)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .inc     (ctr_inc),
        .idx     (round_idx),
        .at_last (at_last)
    );

    assign busy        = ~idle;
    assign round_valid = (state == S_ISSUE);
    assign last_round  = round_valid & at_last;
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_odo_round_scheduler.sv
// Randomized bench for odo_round_scheduler against a job-level model.
// Second instance covers the single-round configuration.
module tb_odo_round_scheduler;

    localparam int ROUNDS  = 84;
    localparam int ROM_LAT = 1;

`ifdef ODO_SCHED_PERIOD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] period_in = '0;
    logic       round_ready = 1'b0;
    logic       busy;
    logic [3:0] rom_period;
    logic [9:0] rom_key = '0;
    logic       round_valid;
    logic [6:0] round_idx;
    logic [9:0] round_key;
    logic       last_round;
    logic       done;
    logic       err;

    logic       start1 = 1'b0;
    logic [3:0] per1 = '0;
    logic       busy1;
    logic [3:0] rom_period1;
    logic [9:0] rom_key1 = '0;
    logic       valid1;
    logic [0:0] idx1;
    logic [9:0] key1;
    logic       last1;
    logic       done1;
    logic       err1;

    logic [9:0] tab [10];

    int n_chk = 0;
    int n_fail = 0;

    bit         m_act;
    int         m_t;
    int         m_nx;
    logic [3:0] m_per;
    logic [9:0] m_key;
    logic [9:0] m_rk;
    bit         m_err;

    always #5 clk = ~clk;

`ifndef ODO_SCHED_PERIOD_CHECK_EN
    assign err  = 1'b0;
    assign err1 = 1'b0;
`endif

    odo_round_scheduler #(
        .ROUNDS (ROUNDS),
        .KEY_W  (10),
        .ROM_LAT(ROM_LAT),
        .IDX_W  (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .period_in  (period_in),
        .busy       (busy),
        .rom_period (rom_period),
        .rom_key    (rom_key),
        .round_valid(round_valid),
        .round_ready(round_ready),
        .round_idx  (round_idx),
        .round_key  (round_key),
        .last_round (last_round),
        .done       (done)
`ifdef ODO_SCHED_PERIOD_CHECK_EN
        ,
        .err        (err)
`endif
    );

    odo_round_scheduler #(
        .ROUNDS (1),
        .KEY_W  (10),
        .ROM_LAT(ROM_LAT),
        .IDX_W  (1)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .period_in  (per1),
        .busy       (busy1),
        .rom_period (rom_period1),
        .rom_key    (rom_key1),
        .round_valid(valid1),
        .round_ready(1'b1),
        .round_idx  (idx1),
        .round_key  (key1),
        .last_round (last1),
        .done       (done1)
`ifdef ODO_SCHED_PERIOD_CHECK_EN
        ,
        .err        (err1)
`endif
    );

    // External key ROMs: one-cycle registered, hold on unknown period
    always @(posedge clk) begin
        if (rom_period < 4'd10) rom_key <= tab[rom_period];
        if (rom_period1 < 4'd10) rom_key1 <= tab[rom_period1];
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit valid_exp();
        return m_act && m_t >= ROM_LAT + 2 && m_nx < ROUNDS;
    endfunction

    // Job-level model advanced across one rising edge
    task automatic model_edge(input bit st, input logic [3:0] p,
                              input bit rdy, input bit rs);
        bit ev;
        ev = valid_exp();
        m_err = 1'b0;
        if (rs) begin
            m_act = 1'b0;
            m_nx  = 0;
            m_t   = 0;
            m_per = '0;
            m_rk  = tab[0];
        end else if (!m_act) begin
            if (st) begin
                if (CHK && p > 4'd9) begin
                    m_err = 1'b1;
                end else begin
                    m_act = 1'b1;
                    m_t   = 1;
                    m_nx  = 0;
                    m_per = p;
                    if (p < 4'd10) m_rk = tab[p];
                    m_key = m_rk;
                end
            end
        end else if (m_nx == ROUNDS) begin
            m_act = 1'b0;
        end else begin
            m_t++;
            if (ev && rdy) m_nx++;
        end
    endtask

    task automatic compare();
        bit ev;
        ev = valid_exp();
        check("busy", 32'(busy), 32'(m_act));
        check("valid", 32'(round_valid), 32'(ev));
        check("last", 32'(last_round),
              32'(ev && m_nx == ROUNDS - 1));
        check("done", 32'(done), 32'(m_act && m_nx == ROUNDS));
        check("rom_period", 32'(rom_period), 32'(m_per));
        check("err", 32'(err), 32'(m_err));
        if (ev) begin
            check("idx", 32'(round_idx), 32'(m_nx));
            check("key", 32'(round_key), 32'(m_key));
        end
    endtask

    task automatic cyc(input bit st, input logic [3:0] p,
                       input bit rdy, input bit rs);
        start       = st;
        period_in   = p;
        round_ready = rdy;
        rst_n       = !rs;
        @(posedge clk);
        model_edge(st, p, rdy, rs);
        @(negedge clk);
        compare();
    endtask

    // mode 0: ready high, 1: ready 1,0,0,1 plus a start mid-job,
    // 2: random ready and random start pulses
    task automatic run_job(input logic [3:0] p, input int mode,
                           input int rst_at);
        int n;
        bit r;
        bit s;
        logic [3:0] q;
        cyc(1'b1, p, 1'b1, 1'b0);
        n = 0;
        while (m_act && n < 1000) begin
            r = 1'b1;
            s = 1'b0;
            q = p;
            if (mode == 1) begin
                r = (n % 4 == 0) || (n % 4 == 3);
                if (n == 20) begin
                    s = 1'b1;
                    q = 4'd4;
                end
            end else if (mode == 2) begin
                r = 1'($urandom_range(0, 1));
                s = ($urandom_range(0, 7) == 0);
                q = 4'($urandom_range(0, 15));
            end
            if (rst_at >= 0 && valid_exp() && m_nx == rst_at) begin
                cyc(s, q, r, 1'b1);
                check("rst_idx", 32'(round_idx), 32'd0);
                check("rst_key", 32'(round_key), 32'd0);
                check("rst_last", 32'(last_round), 32'd0);
            end else begin
                cyc(s, q, r, 1'b0);
            end
            n++;
        end
        check("job_bound", 32'(n < 1000), 32'd1);
    endtask

    logic [4:0] xb;
    logic [4:0] xv;
    logic [4:0] xd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        tab[0] = 10'h0b5; tab[1] = 10'h1e3;
        tab[2] = 10'h26c; tab[3] = 10'h3a1;
        tab[4] = 10'h07f; tab[5] = 10'h152;
        tab[6] = 10'h2d8; tab[7] = 10'h349;
        tab[8] = 10'h0c6; tab[9] = 10'h21a;
        m_act = 1'b0; m_t = 0; m_nx = 0;
        m_per = '0; m_key = '0; m_rk = tab[0]; m_err = 1'b0;

        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        check("reset_idx", 32'(round_idx), 32'd0);
        check("reset_key", 32'(round_key), 32'd0);
        check("reset_busy1", 32'(busy1), 32'd0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);

        run_job(4'd0, 0, -1);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        run_job(4'd2, 1, -1);
        repeat (3) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        run_job(4'd5, 2, 40);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        run_job(4'd3, 0, -1);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);

        run_job(4'd11, 0, -1);
        repeat (2) cyc(1'b0, 4'd0, 1'b1, 1'b0);

        // start held high: jobs chain on the IDLE cycle after done
        repeat (2 * (ROUNDS + ROM_LAT + 3) + 4)
            cyc(1'b1, 4'd6, 1'b1, 1'b0);
        repeat (ROUNDS + 6) cyc(1'b0, 4'd0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 7) == 0,
                4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 499) == 0);
        end
        repeat (ROUNDS + 6) cyc(1'b0, 4'd0, 1'b1, 1'b0);

        // Single-round configuration
        xb = 5'b01111;
        xv = 5'b00100;
        xd = 5'b01000;
        start1 = 1'b1;
        per1   = 4'd7;
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        start1 = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            check("r1_busy", 32'(busy1), 32'(xb[t-1]));
            check("r1_valid", 32'(valid1), 32'(xv[t-1]));
            check("r1_last", 32'(last1), 32'(xv[t-1]));
            check("r1_done", 32'(done1), 32'(xd[t-1]));
            if (xv[t-1]) begin
                check("r1_idx", 32'(idx1), 32'd0);
                check("r1_key", 32'(key1), 32'(tab[7]));
            end
            cyc(1'b0, 4'd0, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
